// File: rtl/audio_pkg.sv
// Shared audio PWM definitions: sample width, PWM period and the
// demodulator state encoding. Also used by the PWM modulator.
package audio_pkg;

  localparam int PWM_WIDTH  = 11;
  localparam int PWM_PERIOD = 2048;

  typedef enum logic [0:0] {
    SEARCH  = 1'b0,
    MEASURE = 1'b1
  } demod_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Brings an asynchronous level into the clock domain through two flops,
// adds one delay register and flags the rising edge of the synchronized
// level. Shared with the button debouncer path.
module pwm_edge_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic dly_q;

  // Two-flop synchronizer followed by a one-cycle delay of the clean level.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~dly_q;

endmodule

// File: rtl/pwm_demod.sv
// PWM audio demodulator: locks onto the PWM period from rising edges,
// counts the high time of each period and emits the recovered sample with
// a one-cycle valid strobe. A window with no closing edge is still closed
// by the period counter while locked, so duty 0 and constant high decode.
// Optional build macro PWM_DEMOD_AVG_EN: output is the mean of the last
// four window results instead of the raw result.
module pwm_demod
  import audio_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH,
  parameter int PERIOD = PWM_PERIOD
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] sample,
  output logic             sample_valid,
  output logic             locked,
  output logic             period_err
);

  localparam int             CW       = WIDTH + 1;
  localparam logic [CW-1:0]  PERIOD_C = CW'(PERIOD);
  localparam logic [CW-1:0]  ONE_C    = CW'(1);
  localparam logic [CW-1:0]  ZERO_C   = {CW{1'b0}};

  // Clamp a high-time count into the sample range; a full-period count
  // (constant high) maps to the largest code.
  function automatic logic [WIDTH-1:0] sat(input logic [CW-1:0] x);
    logic [WIDTH-1:0] r;
    if (x >= PERIOD_C) r = WIDTH'(PERIOD - 1);
    else               r = x[WIDTH-1:0];
    return r;
  endfunction

  logic             s;
  logic             rise_s;
  logic [CW-1:0]    s_ext;
  logic             at_period_s;
  logic             close_s;
  logic             err_s;
  logic [WIDTH-1:0] win_res_d;
  logic [WIDTH-1:0] close_val_d;

  demod_state_e     state_q;
  logic [CW-1:0]    period_cnt_q;
  logic [CW-1:0]    high_cnt_q;
  logic [WIDTH-1:0] sample_q;
  logic             valid_q;
  logic             locked_q;
  logic             perr_q;

  pwm_edge_sync u_sync (
    .clk_i   (CLK100MHZ),
    .reset_i (reset),
    .async_i (pwm_in),
    .level_o (s),
    .rise_o  (rise_s)
  );

  assign s_ext       = {{WIDTH{1'b0}}, s};
  assign at_period_s = (period_cnt_q == PERIOD_C);
  assign close_s     = (state_q == MEASURE) && at_period_s && (rise_s || locked_q);
  assign err_s       = (state_q == MEASURE) && rise_s && !at_period_s;
  assign win_res_d   = sat(high_cnt_q);

`ifdef PWM_DEMOD_AVG_EN
  logic [WIDTH-1:0] hist0_q;
  logic [WIDTH-1:0] hist1_q;
  logic [WIDTH-1:0] hist2_q;
  logic [WIDTH+1:0] avg_sum_d;

  assign avg_sum_d   = {2'b00, win_res_d} + {2'b00, hist0_q}
                     + {2'b00, hist1_q}   + {2'b00, hist2_q};
  assign close_val_d = WIDTH'(avg_sum_d >> 2);

  // Keep the three previous window results; a period error restarts the mean.
  always_ff @(posedge CLK100MHZ) begin
    if (reset || err_s) begin
      hist0_q <= {WIDTH{1'b0}};
      hist1_q <= {WIDTH{1'b0}};
      hist2_q <= {WIDTH{1'b0}};
    end else if (close_s) begin
      hist0_q <= win_res_d;
      hist1_q <= hist0_q;
      hist2_q <= hist1_q;
    end
  end
`else
  assign close_val_d = win_res_d;
`endif

  // Lock/measure state machine with window counters and registered outputs.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q      <= SEARCH;
      period_cnt_q <= ZERO_C;
      high_cnt_q   <= ZERO_C;
      sample_q     <= {WIDTH{1'b0}};
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (rise_s) begin
            state_q      <= MEASURE;
            period_cnt_q <= ONE_C;
            high_cnt_q   <= ONE_C;
          end else begin
            period_cnt_q <= ZERO_C;
            high_cnt_q   <= ZERO_C;
          end
        end
        MEASURE: begin
          if (rise_s && at_period_s) begin
            sample_q     <= close_val_d;
            valid_q      <= 1'b1;
            locked_q     <= 1'b1;
            period_cnt_q <= ONE_C;
            high_cnt_q   <= ONE_C;
          end else if (rise_s) begin
            // Edge off-period: realign the window onto this edge.
            perr_q       <= 1'b1;
            locked_q     <= 1'b0;
            period_cnt_q <= ONE_C;
            high_cnt_q   <= ONE_C;
          end else if (at_period_s && locked_q) begin
            // No edge at the boundary: close on timing alone.
            sample_q     <= close_val_d;
            valid_q      <= 1'b1;
            period_cnt_q <= ONE_C;
            high_cnt_q   <= s_ext;
          end else if (at_period_s) begin
            state_q      <= SEARCH;
            period_cnt_q <= ZERO_C;
            high_cnt_q   <= ZERO_C;
          end else begin
            period_cnt_q <= period_cnt_q + ONE_C;
            high_cnt_q   <= high_cnt_q + s_ext;
          end
        end
        default: begin
          state_q      <= SEARCH;
          period_cnt_q <= ZERO_C;
          high_cnt_q   <= ZERO_C;
          locked_q     <= 1'b0;
        end
      endcase
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign period_err   = perr_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Bench for pwm_demod: drives PWM streams cycle by cycle and compares every
// output on every cycle against a window-level reference model that works
// from the recorded pin waveform (rise positions and high-time sums).
module tb_pwm_demod;

  localparam int WIDTH  = 11;
  localparam int PERIOD = 2048;
  localparam int NCYC   = 90000;

  logic             CLK100MHZ;
  logic             reset;
  logic             pwm_in;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             locked;
  logic             period_err;

  pwm_demod #(.WIDTH(WIDTH), .PERIOD(PERIOD)) dut (
    .CLK100MHZ    (CLK100MHZ),
    .reset        (reset),
    .pwm_in       (pwm_in),
    .sample       (sample),
    .sample_valid (sample_valid),
    .locked       (locked),
    .period_err   (period_err)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit vhist [0:NCYC-1];

  // reference model state
  int m_start  = -1;
  bit m_locked = 1'b0;
  int m_sample = 0;
  bit e_valid  = 1'b0;
  bit e_perr   = 1'b0;
  int m_hist [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, req);
    end
  endtask

  task automatic model_reset();
    m_start  = -1;
    m_locked = 1'b0;
    m_sample = 0;
    e_valid  = 1'b0;
    e_perr   = 1'b0;
    for (int i = 0; i < 3; i++) m_hist[i] = 0;
  endtask

  // Closing a window: the result is the number of high pin cycles in it,
  // clamped to the top code.
  task automatic model_close(input int first, input int last_excl);
    int hi;
    int r;
    hi = 0;
    for (int i = first; i < last_excl; i++) hi += int'(vhist[i]);
    r = (hi >= PERIOD) ? PERIOD - 1 : hi;
`ifdef PWM_DEMOD_AVG_EN
    m_sample  = (r + m_hist[0] + m_hist[1] + m_hist[2]) / 4;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = r;
`else
    m_sample = r;
`endif
    e_valid = 1'b1;
  endtask

  // Apply the window rules to pin sample j.
  task automatic model_step(input int j);
    bit rise;
    int len;
    e_valid = 1'b0;
    e_perr  = 1'b0;
    rise = vhist[j] && ((j == 0) || !vhist[j-1]);
    if (m_start < 0) begin
      if (rise) m_start = j;
    end else begin
      len = j - m_start;
      if (rise) begin
        if (len == PERIOD) begin
          model_close(m_start, j);
          m_locked = 1'b1;
        end else begin
          e_perr   = 1'b1;
          m_locked = 1'b0;
          for (int i = 0; i < 3; i++) m_hist[i] = 0;
        end
        m_start = j;
      end else if (len == PERIOD) begin
        if (m_locked) begin
          model_close(m_start, j);
          m_start = j;
        end else begin
          m_start = -1;
        end
      end
    end
  endtask

  // One clock: drive the pin, advance, then compare all outputs.
  task automatic tick(input bit v);
    pwm_in = v;
    vhist[cyc] = v;
    @(posedge CLK100MHZ);
    #1;
    cyc++;
    if (reset) model_reset();
    else if (cyc >= 3) model_step(cyc - 3);
    chk("sample_valid", 32'(sample_valid), 32'(e_valid));
    chk("period_err",   32'(period_err),   32'(e_perr));
    chk("locked",       32'(locked),       32'(m_locked));
    chk("sample",       32'(sample),       32'(m_sample));
  endtask

  task automatic gen_period(input int len, input int duty);
    for (int i = 0; i < len; i++) tick(i < duty);
  endtask

  initial begin
    model_reset();
    reset  = 1'b1;
    pwm_in = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b0);
    chk("reset_sample", 32'(sample), 32'd0);
    chk("reset_locked", 32'(locked), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b0);

    // half duty: lock, then 1024 per window
    for (int p = 0; p < 5; p++) gen_period(PERIOD, 1024);
`ifndef PWM_DEMOD_AVG_EN
    chk("half_sample", 32'(sample), 32'd1024);
`endif
    chk("half_locked", 32'(locked), 32'd1);

    // random duties
    for (int p = 0; p < 5; p++) gen_period(PERIOD, int'($urandom_range(2047, 1)));

    // duty 700, then held low for whole windows
    for (int p = 0; p < 2; p++) gen_period(PERIOD, 700);
    for (int p = 0; p < 3; p++) gen_period(PERIOD, 0);
`ifndef PWM_DEMOD_AVG_EN
    chk("low_sample", 32'(sample), 32'd0);
`endif
    chk("low_locked", 32'(locked), 32'd1);

    // held high: saturates to top code while staying locked
    for (int p = 0; p < 3; p++) gen_period(PERIOD, PERIOD);
`ifndef PWM_DEMOD_AVG_EN
    chk("high_sample", 32'(sample), 32'd2047);
`endif
    chk("high_locked", 32'(locked), 32'd1);

    // off-period edges, then back to the nominal period
    for (int p = 0; p < 4; p++) gen_period(2000, 500);
    chk("offp_locked", 32'(locked), 32'd0);
    for (int p = 0; p < 3; p++) gen_period(PERIOD, 300);
`ifndef PWM_DEMOD_AVG_EN
    chk("relock_sample", 32'(sample), 32'd300);
`endif
    chk("relock_locked", 32'(locked), 32'd1);

    // reset 1000 cycles into a window
    gen_period(PERIOD, 700);
    for (int i = 0; i < 1000; i++) tick(i < 700);
    reset = 1'b1;
    tick(1'b0);
    chk("midrst_sample", 32'(sample), 32'd0);
    chk("midrst_valid",  32'(sample_valid), 32'd0);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_perr",   32'(period_err), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b0);

    // extreme duties after relock
    for (int p = 0; p < 4; p++) gen_period(PERIOD, 1);
`ifndef PWM_DEMOD_AVG_EN
    chk("duty1_sample", 32'(sample), 32'd1);
`endif
    for (int p = 0; p < 4; p++) gen_period(PERIOD, 2047);
`ifndef PWM_DEMOD_AVG_EN
    chk("duty2047_sample", 32'(sample), 32'd2047);
`endif
    chk("duty2047_locked", 32'(locked), 32'd1);

    // flush: trailing low input free-runs closes
    for (int i = 0; i < 2100; i++) tick(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
